uart_rx_engine: RTL and testbench

Receive-side control engine of the full UART. Synchronizes the serial RX line, detects and qualifies start bits, times each bit at its midpoint, and drives `SHIFT`/`SDI` into the downstream 10-bit receive shift register. It then reads that register's `Q` back, right-justifies the data for 7/8-bit and parity/no-parity frames, and presents the byte with `RXRDY` and parity, framing and overflow status to the bus interface.

---
 rtl/uart_rx_engine.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_engine.sv
// uart_rx_engine
// Receive-side control engine of the UART. Synchronizes the RX line, qualifies
// start bits at half a bit time, strobes each bit into an external 10-bit
// shift register at the bit midpoint, then right-justifies the received frame
// read back from that register and reports it with status flags.
//
// Ports
//   clk     system clock
//   rst     synchronous active-high reset
//   RX      asynchronous serial input, idle high
//   BAUD_K  clocks per bit (>= 4, stable while a frame is in progress)
//   EIGHT   1 = 8 data bits, 0 = 7 data bits
//   PEN     parity enable
//   OHEL    1 = odd parity, 0 = even parity
//   READ    one-cycle pulse: host consumed DATA
//   Q       contents of the external receive shift register
//   SHIFT   one-cycle shift strobe to the shift register
//   SDI     synchronized RX bit to the shift register
//   DATA    received byte (bit 7 = 0 in 7-bit mode)
//   RXRDY   byte available
//   PERR    parity error
//   FERR    framing error (stop bit sampled as 0)
//   OVF     a frame completed while RXRDY was still set
//
// Timing: the first cycle SDI is low to the first cycle SHIFT is high is
// exactly (BAUD_K>>1) + BAUD_K + 1 clocks; later SHIFTs follow every BAUD_K
// clocks. SHIFT is raised one cycle early (timer == BAUD_K-2) so that, being
// registered, it is high in the cycle where the bit timer hits terminal count.
module uart_rx_engine #(
    parameter int K_W = 19
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           RX,
    input  logic [K_W-1:0] BAUD_K,
    input  logic           EIGHT,
    input  logic           PEN,
    input  logic           OHEL,
    input  logic           READ,
    input  logic [9:0]     Q,
    output logic           SHIFT,
    output logic           SDI,
    output logic [7:0]     DATA,
    output logic           RXRDY,
    output logic           PERR,
    output logic           FERR,
    output logic           OVF
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t         state_r;
    logic           sync_a_r;
    logic           sdi_r;
    logic           shift_r;
    logic [K_W-1:0] timer_r;
    logic [3:0]     bit_cnt_r;
    logic [7:0]     data_r;
    logic           rxrdy_r;
    logic           perr_r;
    logic           ferr_r;
    logic           ovf_r;

    logic [K_W-1:0] half_k_s;
    logic [K_W-1:0] last_k_s;
    logic [K_W-1:0] pre_k_s;
    logic [3:0]     n_bits_s;
    logic [7:0]     rx_data_s;
    logic           rx_par_s;
    logic           perr_s;

    // Even-parity (XOR reduction) of a byte.
    function automatic logic parity8(input logic [7:0] v);
        return ^v;
    endfunction

    assign SHIFT = shift_r;
    assign SDI   = sdi_r;
    assign DATA  = data_r;
    assign RXRDY = rxrdy_r;
    assign PERR  = perr_r;
    assign FERR  = ferr_r;
    assign OVF   = ovf_r;

    assign half_k_s = BAUD_K >> 1;
    assign last_k_s = BAUD_K - K_W'(1);
    assign pre_k_s  = BAUD_K - K_W'(2);
    assign n_bits_s = 4'd8 + {3'b000, EIGHT} + {3'b000, PEN};

    // Right-justify the frame held in Q; the stop bit always sits in Q[9].
    always_comb begin
        rx_data_s = 8'h00;
        rx_par_s  = 1'b0;
        case ({EIGHT, PEN})
            2'b11: begin
                rx_data_s = Q[7:0];
                rx_par_s  = Q[8];
            end
            2'b10: begin
                rx_data_s = Q[8:1];
                rx_par_s  = 1'b0;
            end
            2'b01: begin
                rx_data_s = {1'b0, Q[7:1]};
                rx_par_s  = Q[8];
            end
            default: begin
                // 7 data bits, no parity
                rx_data_s = {1'b0, Q[8:2]};
                rx_par_s  = 1'b0;
            end
        endcase
    end

    assign perr_s = PEN & ((parity8(rx_data_s) ^ OHEL) != rx_par_s);

    // Two-flop synchronizer for the asynchronous RX line.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a_r <= 1'b1;
            sdi_r    <= 1'b1;
        end else begin
            sync_a_r <= RX;
            sdi_r    <= sync_a_r;
        end
    end

    // Frame FSM: start qualification, bit timing and SHIFT generation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            timer_r   <= '0;
            bit_cnt_r <= 4'd0;
            shift_r   <= 1'b0;
        end else begin
            shift_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    timer_r   <= '0;
                    bit_cnt_r <= 4'd0;
                    if (!sdi_r) begin
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (timer_r == half_k_s) begin
                        timer_r <= '0;
                        // still low at mid start bit: genuine start
                        state_r <= sdi_r ? ST_IDLE : ST_DATA;
                    end else begin
                        timer_r <= timer_r + K_W'(1);
                    end
                end
                ST_DATA: begin
                    if (timer_r == pre_k_s) begin
                        shift_r <= 1'b1;
                    end
                    if (timer_r == last_k_s) begin
                        timer_r   <= '0;
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        if (bit_cnt_r == (n_bits_s - 4'd1)) begin
                            state_r <= ST_DONE;
                        end
                    end else begin
                        timer_r <= timer_r + K_W'(1);
                    end
                end
                ST_DONE: begin
                    timer_r   <= '0;
                    bit_cnt_r <= 4'd0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    timer_r   <= '0;
                    bit_cnt_r <= 4'd0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // Receive holding register and status flags; DONE loads win over READ.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r  <= 8'h00;
            rxrdy_r <= 1'b0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (state_r == ST_DONE) begin
            data_r  <= rx_data_s;
            perr_r  <= perr_s;
            ferr_r  <= ~Q[9];
            rxrdy_r <= 1'b1;
            if (rxrdy_r && !READ) begin
                ovf_r <= 1'b1;
            end
        end else if (READ && rxrdy_r) begin
            rxrdy_r <= 1'b0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine. Models the external shift register,
// serializes frames onto RX and checks SHIFT timing plus the reported byte and
// status against expectations computed from the frame contents.
module tb_uart_rx_engine;

    localparam int K_W = 19;

    logic           clk = 1'b0;
    logic           rst;
    logic           RX;
    logic [K_W-1:0] BAUD_K;
    logic           EIGHT;
    logic           PEN;
    logic           OHEL;
    logic           READ;
    logic [9:0]     Q;
    logic           SHIFT;
    logic           SDI;
    logic [7:0]     DATA;
    logic           RXRDY;
    logic           PERR;
    logic           FERR;
    logic           OVF;

    uart_rx_engine #(.K_W(K_W)) dut (
        .clk(clk), .rst(rst), .RX(RX), .BAUD_K(BAUD_K), .EIGHT(EIGHT),
        .PEN(PEN), .OHEL(OHEL), .READ(READ), .Q(Q), .SHIFT(SHIFT), .SDI(SDI),
        .DATA(DATA), .RXRDY(RXRDY), .PERR(PERR), .FERR(FERR), .OVF(OVF)
    );

    always #5 clk = ~clk;

    // External 10-bit receive shift register (shifts right, new bit into [9]).
    logic [9:0] q_model;
    always @(posedge clk) begin
        if (rst) q_model <= 10'd0;
        else if (SHIFT) q_model <= {SDI, q_model[9:1]};
    end
    assign Q = q_model;

    // Record cycle numbers of SHIFT pulses and SDI falling edges.
    int   cyc = 0;
    int   shift_total = 0;
    int   fall_total = 0;
    int   shift_cyc [0:511];
    int   fall_cyc  [0:511];
    logic prev_sdi = 1'b1;
    always @(posedge clk) begin
        #1;
        cyc <= cyc + 1;
        if (SHIFT === 1'b1) begin
            shift_cyc[shift_total[8:0]] <= cyc + 1;
            shift_total <= shift_total + 1;
        end
        if (prev_sdi === 1'b1 && SDI === 1'b0) begin
            fall_cyc[fall_total[8:0]] <= cyc + 1;
            fall_total <= fall_total + 1;
        end
        prev_sdi <= SDI;
    end

    int checks = 0;
    int errors = 0;

    // expected host-visible state
    logic [7:0] exp_data  = 8'h00;
    logic       exp_rxrdy = 1'b0;
    logic       exp_perr  = 1'b0;
    logic       exp_ferr  = 1'b0;
    logic       exp_ovf   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".DATA"},  32'(DATA),  32'(exp_data));
        chk({tag, ".RXRDY"}, 32'(RXRDY), 32'(exp_rxrdy));
        chk({tag, ".PERR"},  32'(PERR),  32'(exp_perr));
        chk({tag, ".FERR"},  32'(FERR),  32'(exp_ferr));
        chk({tag, ".OVF"},   32'(OVF),   32'(exp_ovf));
    endtask

    task automatic host_read(input string tag);
        @(negedge clk); READ = 1'b1;
        @(negedge clk); READ = 1'b0;
        if (exp_rxrdy) begin
            exp_rxrdy = 1'b0; exp_perr = 1'b0; exp_ferr = 1'b0; exp_ovf = 1'b0;
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    // Serialize one frame. par_ok=0 sends the wrong parity bit. abort_at>0
    // stops driving once that many SHIFTs were seen; read_at_done pulses READ
    // in the cycle after the last SHIFT.
    task automatic send_frame(input string tag, input logic [7:0] b, input int k,
                              input logic e8, input logic pe, input logic od,
                              input logic par_ok, input logic stop,
                              input int abort_at, input logic read_at_done,
                              output logic aborted);
        logic       bits [0:11];
        int         nb, n, sb, fb, rd_phase, bad;
        logic [7:0] d;
        aborted = 1'b0;
        @(negedge clk);
        BAUD_K = K_W'(k); EIGHT = e8; PEN = pe; OHEL = od;
        d  = e8 ? b : {1'b0, b[6:0]};
        n  = 8 + int'(e8) + int'(pe);
        nb = 0;
        bits[nb] = 1'b0; nb++;
        for (int i = 0; i < 7 + int'(e8); i++) begin
            bits[nb] = b[i]; nb++;
        end
        if (pe) begin
            bits[nb] = ($countones(d) % 2 == 1) ^ od ^ ~par_ok; nb++;
        end
        bits[nb] = stop; nb++;
        sb = shift_total;
        fb = fall_total;
        rd_phase = 0;
        for (int j = 0; j < nb && !aborted; j++) begin
            for (int c = 0; c < k && !aborted; c++) begin
                if (j != 0 || c != 0) @(negedge clk);
                RX = bits[j];
                if (abort_at > 0 && (shift_total - sb) >= abort_at) aborted = 1'b1;
                if (read_at_done) begin
                    if (rd_phase == 0 && (shift_total - sb) == n) rd_phase = 1;
                    else if (rd_phase == 1) begin READ = 1'b1; rd_phase = 2; end
                    else if (rd_phase == 2) begin READ = 1'b0; rd_phase = 3; end
                end
            end
        end
        if (!aborted) begin
            @(negedge clk);
            RX = 1'b1;
            READ = 1'b0;
            repeat (2 * k + 10) @(negedge clk);
            // reference: frame outcome from its contents
            exp_data = d;
            exp_perr = pe && !par_ok;
            exp_ferr = !stop;
            if (exp_rxrdy && !read_at_done) exp_ovf = 1'b1;
            exp_rxrdy = 1'b1;
            chk({tag, ".nshift"}, 32'(shift_total - sb), 32'(n));
            if (shift_total > sb && fall_total > fb)
                chk({tag, ".latency"}, 32'(shift_cyc[sb[8:0]] - fall_cyc[fb[8:0]]),
                    32'(k / 2 + k + 1));
            bad = 0;
            for (int i = 1; i < n && (sb + i) < shift_total; i++)
                if (shift_cyc[(sb + i) % 512] - shift_cyc[(sb + i - 1) % 512] != k) bad++;
            chk({tag, ".gaps"}, 32'(bad), 32'd0);
            if (read_at_done) chk({tag, ".read_pulsed"}, 32'(rd_phase), 32'd3);
            check_outputs(tag);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic ab;
        int   sb;
        logic [7:0] rb;
        int   rk;
        logic re8, rpe, rod, rok, rst_bit;
        rst = 1'b1; RX = 1'b1; READ = 1'b0;
        BAUD_K = K_W'(16); EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0;
        repeat (4) @(negedge clk);
        check_outputs("reset");
        chk("reset.SDI", 32'(SDI), 32'd1);
        chk("reset.SHIFT", 32'(SHIFT), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1
        send_frame("8n1_a5", 8'hA5, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, ab);
        chk("8n1_a5.lit", 32'(DATA), 32'h0000_00A5);
        host_read("read1");
        // 7-bit odd parity, good then bad parity
        send_frame("7o1_good", 8'h55, 16, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0, ab);
        chk("7o1_good.PERR_lit", 32'(PERR), 32'd0);
        send_frame("7o1_bad", 8'h55, 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, ab);
        chk("7o1_bad.PERR_lit", 32'(PERR), 32'd1);
        host_read("read2");
        // 8-bit even parity, bad stop
        send_frame("8e1_ferr", 8'h3C, 16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, ab);
        chk("8e1_ferr.FERR_lit", 32'(FERR), 32'd1);
        host_read("read3");

        // glitch / false start
        sb = shift_total;
        @(negedge clk); RX = 1'b0;
        repeat (3) @(negedge clk);
        RX = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch.nshift", 32'(shift_total - sb), 32'd0);
        check_outputs("glitch");

        // overflow and READ interplay
        send_frame("ovf_11", 8'h11, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, ab);
        send_frame("ovf_22", 8'h22, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, ab);
        chk("ovf_22.OVF_lit", 32'(OVF), 32'd1);
        host_read("ovf_read");
        host_read("read_idle");
        send_frame("rd_done_33", 8'h33, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b1, ab);
        chk("rd_done_33.RXRDY_lit", 32'(RXRDY), 32'd1);

        // reset mid-frame after the 4th SHIFT
        send_frame("abort", 8'h5A, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b0, ab);
        chk("abort.reached", 32'(ab), 32'd1);
        rst = 1'b1; RX = 1'b1;
        @(negedge clk);
        exp_data = 8'h00; exp_rxrdy = 1'b0; exp_perr = 1'b0; exp_ferr = 1'b0; exp_ovf = 1'b0;
        check_outputs("midrst");
        chk("midrst.SDI", 32'(SDI), 32'd1);
        chk("midrst.SHIFT", 32'(SHIFT), 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check_outputs("midrst_quiet");
        send_frame("after_rst_7e", 8'h7E, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, ab);
        host_read("read4");

        // randomized frames
        for (int f = 0; f < 10; f++) begin
            rb  = 8'($urandom_range(0, 255));
            rk  = int'($urandom_range(4, 20));
            re8 = 1'($urandom_range(0, 1));
            rpe = 1'($urandom_range(0, 1));
            rod = 1'($urandom_range(0, 1));
            rok = ($urandom_range(0, 2) != 0);
            rst_bit = ($urandom_range(0, 3) != 0);
            send_frame($sformatf("rnd%0d", f), rb, rk, re8, rpe, rod, rok, rst_bit, 0, 1'b0, ab);
            if ($urandom_range(0, 1) == 1) host_read($sformatf("rnd%0d_read", f));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
